alu32_seq_driver: RTL and testbench
===================================

// Module: alu32_seq_driver
// PURPOSE
//  Driver side of the ALU16Bit interface: accepts 32-bit ALU commands over a valid/ready
//  port and executes them on one ALU16Bit instance in successive 16-bit passes.
//  Chains carry between passes, forms SLT by feeding the high-half set back as less,
//  and returns a registered 32-bit result plus flags over a valid/ready port.
// PARAMETERS
//  OP_SUB   3'b110  op code for subtract (op[2] = b-invert; low-pass cin = op[2])
//  OP_SLT   3'b111  op code for set-less-than (three-pass sequence)
// PORTS
//  clk        in   1   single clock; all state changes on rising edge
//  rst_n      in   1   reset, synchronous, active-low
//  cmd_valid  in   1   command present
//  cmd_ready  out  1   command accepted when cmd_valid & cmd_ready
//  cmd_op     in   3   ALU16Bit op: [2] b-invert, [1:0] 00 AND, 01 OR, 10 ADD, 11 SLT
//  cmd_a      in   32  operand A
//  cmd_b      in   32  operand B
//  rsp_valid  out  1   result present
//  rsp_ready  in   1   result consumed when rsp_valid & rsp_ready
//  rsp_result out  32  result
//  rsp_cout   out  1   carry out of bit 31
//  rsp_ovf    out  1   signed overflow of 32-bit ADD/SUB
//  rsp_zero   out  1   rsp_result == 0
// BEHAVIOUR
//  - Reset (rst_n low at edge): state IDLE; cmd_ready 1; rsp_valid 0; rsp_result,
//    rsp_cout, rsp_ovf, rsp_zero all 0; operand/carry registers cleared.
//  - Reset mid-operation aborts the command; no response is produced for it.
//  - FSM: IDLE -> LO -> HI -> (FIX if op==OP_SLT) -> DONE -> IDLE.
//  - IDLE: cmd_ready=1; on handshake latch op/a/b, go LO. cmd_ready=0 in all other states.
//  - LO: ALU gets a[15:0], b[15:0], cin=op[2], less=0; capture cout->carry, result->r[15:0],
//    zero->z_lo.
//  - HI: ALU gets a[31:16], b[31:16], cin=carry, less=0; capture result->r[31:16], cout,
//    overflow, set, zero->z_hi. Non-SLT -> DONE.
//  - FIX (SLT only): rerun low half with cin=op[2], less=captured set; r[15:0] = new result;
//    r[31:16] forced 0.
//  - DONE: rsp_valid=1; outputs held stable until rsp_ready; on handshake -> IDLE,
//    rsp_valid drops next cycle, next command accepted the cycle after that.
//  - Latency handshake-to-rsp_valid: 3 cycles (AND/OR/ADD/SUB), 4 cycles (SLT).
//  - Throughput: one command per 4 cycles (5 for SLT) with rsp_ready held high.
//  - rsp_zero = z_lo & z_hi, except SLT: rsp_zero = ~r[0].
//  - rsp_cout/rsp_ovf from HI pass; for AND/OR/SLT forced 0.
//  - cmd_valid while busy is ignored (not latched); inputs sampled only at handshake.
//  - Undefined op codes (e.g. 3'b011, 3'b1x0/1x1 beyond listed) pass to ALU unchanged,
//    use the 2-pass sequence, flags as for ADD/SUB.
// CONFIGURATION
//  ALU32_SEQ_FLAGS_EN defined: rsp_cout, rsp_ovf, rsp_zero registered as above.
//  Not defined: flag logic and registers removed; rsp_cout, rsp_ovf, rsp_zero tied 0;
//  result, latency and handshakes unchanged.
// TESTING
//  ADD 0x0001_FFFF + 0x0000_0001 -> result 0x0002_0000, cout 0, ovf 0, zero 0, valid 3 cycles after accept.
//  SUB 0x8000_0000 - 0x0000_0001 -> result 0x7FFF_FFFF, ovf 1, cout 1, zero 0.
//  SUB 0x1234_5678 - 0x1234_5678 -> result 0, zero 1, cout 1; AND 0xF0F0_0000 & 0x0F0F_FFFF -> 0, zero 1.
//  SLT 0xFFFF_FFFF vs 0x0000_0001 -> result 1, zero 0, valid 4 cycles after accept; swapped operands -> 0, zero 1.
//  Backpressure: rsp_ready low 5 cycles in DONE -> rsp_valid and result stable, cmd_ready 0, new cmd_valid ignored.
//  rst_n low during HI of an ADD -> next cycle cmd_ready 1, rsp_valid 0, all rsp_* 0; no response emitted.

Source files
------------

// File: rtl/alu32_seq_driver_if.sv
// alu32_seq_driver_if: command/response bus of the 32-bit sequenced ALU driver.
//   master: issues commands (cmd_valid/op/a/b) and consumes responses (rsp_ready).
//   slave : accepts commands (cmd_ready) and returns rsp_valid/result/cout/ovf/zero.
interface alu32_seq_driver_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [2:0]  cmd_op;
    logic [31:0] cmd_a;
    logic [31:0] cmd_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_result;
    logic        rsp_cout;
    logic        rsp_ovf;
    logic        rsp_zero;
    modport master (
        output cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovf, rsp_zero
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_a, cmd_b, rsp_ready,
        output cmd_ready, rsp_valid, rsp_result, rsp_cout, rsp_ovf, rsp_zero
    );
endinterface

// File: rtl/alu32_seq_driver.sv
// alu32_seq_driver: runs 32-bit ALU commands as successive 16-bit passes on one ALU16Bit.
// Ports:
//   i_clk    clock, all state changes on the rising edge
//   i_rst_n  synchronous active-low reset
//   bus      alu32_seq_driver_if.slave: cmd valid/ready + op/a/b, rsp valid/ready + result/flags
// Optional macro ALU32_SEQ_FLAGS_EN: when defined, rsp_cout/rsp_ovf/rsp_zero are registered;
// otherwise the flag logic is dropped and those outputs are tied 0.
// ALU16Bit op: [2] inverts b, [1:0] = AND/OR/ADD/SLT; SLT drives bit 0 from i_less.
module ALU16Bit (
    input  logic [2:0]  i_op,
    input  logic [15:0] i_a,
    input  logic [15:0] i_b,
    input  logic        i_cin,
    input  logic        i_less,
    output logic [15:0] o_result,
    output logic        o_cout,
    output logic        o_set
`ifdef ALU32_SEQ_FLAGS_EN
    ,
    output logic        o_ovf,
    output logic        o_zero
`endif
);
    logic [15:0] w_bb;
    logic [16:0] w_sum;
    logic        w_ovf;
    assign w_bb  = i_op[2] ? ~i_b : i_b;
    assign w_sum = {1'b0, i_a} + {1'b0, w_bb} + {16'b0, i_cin};
    assign w_ovf = (i_a[15] == w_bb[15]) && (w_sum[15] != i_a[15]);
    assign o_result = i_op[1:0] == 2'b00 ? i_a & w_bb :
                      i_op[1:0] == 2'b01 ? i_a | w_bb :
                      i_op[1:0] == 2'b10 ? w_sum[15:0] : {15'b0, i_less};
    assign o_cout = w_sum[16];
    // Overflow-corrected sign, so the fed-back set is a true signed less-than.
    assign o_set  = w_sum[15] ^ w_ovf;
`ifdef ALU32_SEQ_FLAGS_EN
    assign o_ovf  = w_ovf;
    assign o_zero = ~|o_result;
`endif
endmodule

module alu32_seq_driver #(
    parameter logic [2:0] OP_SUB = 3'b110,
    parameter logic [2:0] OP_SLT = 3'b111
) (
    input logic               i_clk,
    input logic               i_rst_n,
    alu32_seq_driver_if.slave bus
);
    localparam logic [2:0] OP_ADD   = 3'b010;
    // The bit that turns ADD into SUB also supplies the low-pass carry-in.
    localparam logic [2:0] INV_MASK = OP_SUB ^ OP_ADD;

    typedef enum logic [2:0] {S_IDLE, S_LO, S_HI, S_FIX, S_DONE} state_t;

    state_t      r_state;
    logic [2:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_res;
    logic        r_carry;
    logic        r_set;
    logic        r_cmd_ready;
    logic        r_rsp_valid;

    logic        w_hi;
    logic [15:0] w_a;
    logic [15:0] w_b;
    logic        w_cin;
    logic        w_less;
    logic [15:0] w_res;
    logic        w_cout;
    logic        w_set;

    assign w_hi   = r_state == S_HI;
    assign w_a    = w_hi ? r_a[31:16] : r_a[15:0];
    assign w_b    = w_hi ? r_b[31:16] : r_b[15:0];
    assign w_cin  = w_hi ? r_carry : |(r_op & INV_MASK);
    assign w_less = r_state == S_FIX ? r_set : 1'b0;

`ifdef ALU32_SEQ_FLAGS_EN
    logic w_ovf;
    logic w_zero;
    logic w_no_flags;
    logic r_z_lo;
    logic r_cout;
    logic r_ovf;
    logic r_zero;
    // Logical ops and SLT report no carry/overflow; every other code behaves as ADD/SUB.
    assign w_no_flags = r_op == 3'b000 || r_op == 3'b001 || r_op == OP_SLT;
`endif

    ALU16Bit u_alu (
        .i_op     (r_op),
        .i_a      (w_a),
        .i_b      (w_b),
        .i_cin    (w_cin),
        .i_less   (w_less),
        .o_result (w_res),
        .o_cout   (w_cout),
        .o_set    (w_set)
`ifdef ALU32_SEQ_FLAGS_EN
        ,
        .o_ovf    (w_ovf),
        .o_zero   (w_zero)
`endif
    );

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_op        <= 3'b0;
            r_a         <= 32'b0;
            r_b         <= 32'b0;
            r_res       <= 32'b0;
            r_carry     <= 1'b0;
            r_set       <= 1'b0;
            r_cmd_ready <= 1'b1;
            r_rsp_valid <= 1'b0;
`ifdef ALU32_SEQ_FLAGS_EN
            r_z_lo      <= 1'b0;
            r_cout      <= 1'b0;
            r_ovf       <= 1'b0;
            r_zero      <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: if (bus.cmd_valid) begin
                    r_op        <= bus.cmd_op;
                    r_a         <= bus.cmd_a;
                    r_b         <= bus.cmd_b;
                    r_cmd_ready <= 1'b0;
                    r_state     <= S_LO;
                end
                S_LO: begin
                    r_carry     <= w_cout;
                    r_res[15:0] <= w_res;
`ifdef ALU32_SEQ_FLAGS_EN
                    r_z_lo      <= w_zero;
`endif
                    r_state     <= S_HI;
                end
                S_HI: begin
                    r_res[31:16] <= w_res;
                    r_set        <= w_set;
`ifdef ALU32_SEQ_FLAGS_EN
                    r_cout       <= w_no_flags ? 1'b0 : w_cout;
                    r_ovf        <= w_no_flags ? 1'b0 : w_ovf;
                    r_zero       <= r_z_lo & w_zero;
`endif
                    if (r_op == OP_SLT) begin
                        r_state <= S_FIX;
                    end else begin
                        r_state     <= S_DONE;
                        r_rsp_valid <= 1'b1;
                    end
                end
                // Low half rerun with the high-half set fed in as less: result is {31'b0, set}.
                S_FIX: begin
                    r_res       <= {16'b0, w_res};
`ifdef ALU32_SEQ_FLAGS_EN
                    r_zero      <= ~w_res[0];
`endif
                    r_state     <= S_DONE;
                    r_rsp_valid <= 1'b1;
                end
                S_DONE: if (bus.rsp_ready) begin
                    r_rsp_valid <= 1'b0;
                    r_cmd_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.cmd_ready  = r_cmd_ready;
    assign bus.rsp_valid  = r_rsp_valid;
    assign bus.rsp_result = r_res;
`ifdef ALU32_SEQ_FLAGS_EN
    assign bus.rsp_cout   = r_cout;
    assign bus.rsp_ovf    = r_ovf;
    assign bus.rsp_zero   = r_zero;
`else
    assign bus.rsp_cout   = 1'b0;
    assign bus.rsp_ovf    = 1'b0;
    assign bus.rsp_zero   = 1'b0;
`endif
endmodule

// File: tb/tb_alu32_seq_driver.sv
// tb_alu32_seq_driver: randomized and directed self-checking bench for alu32_seq_driver.
module tb_alu32_seq_driver;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu32_seq_driver_if bus();

    alu32_seq_driver dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct packed {
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] res;
        logic [2:0]  fl;
        logic [2:0]  lat;
    } vec_t;

    function automatic logic [2:0] fm(input logic [2:0] x);
`ifdef ALU32_SEQ_FLAGS_EN
        return x;
`else
        return 3'b000 & x;
`endif
    endfunction

    // Returns {zero, ovf, cout, result} from 32-bit arithmetic and a signed compare.
    function automatic logic [34:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] bb;
        logic [31:0] res;
        logic [32:0] full;
        logic        cout;
        logic        ovf;
        bb   = op[2] ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {32'b0, op[2]};
        case (op[1:0])
            2'b00:   res = a & bb;
            2'b01:   res = a | bb;
            2'b10:   res = full[31:0];
            default: res = (op == 3'b111 && $signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        endcase
        cout = full[32];
        ovf  = (a[31] == bb[31]) && (full[31] != a[31]);
        if (op == 3'b000 || op == 3'b001 || op == 3'b111) begin
            cout = 1'b0;
            ovf  = 1'b0;
        end
        return {fm({res == 32'd0, ovf, cout}), res};
    endfunction

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 4))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic run_cmd(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                           input logic rr, output int lat, output int acc, output logic ok);
        int n;
        lat = 0;
        acc = 0;
        n = 0;
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.rsp_ready = rr;
        while (bus.cmd_ready !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        ok = bus.cmd_ready === 1'b1;
        if (ok) begin
            @(negedge clk);
            acc = cyc;
            bus.cmd_valid = 1'b0;
            bus.cmd_op    = 3'($urandom);
            bus.cmd_a     = $urandom;
            bus.cmd_b     = $urandom;
            lat = 1;
            while (bus.rsp_valid !== 1'b1 && lat < 10) begin
                @(negedge clk);
                lat++;
            end
            ok = bus.rsp_valid === 1'b1;
        end else begin
            bus.cmd_valid = 1'b0;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.cmd_valid = 1'b0;
        bus.cmd_op = 3'b0;
        bus.cmd_a = 32'b0;
        bus.cmd_b = 32'b0;
        bus.rsp_ready = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_cmd_ready got %b want 1", bus.cmd_ready);
        end
        checks++;
        if (bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_result, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero} !== 35'b0) begin
            errors++;
            $display("FAIL reset_rsp got %h %b%b%b want 0", bus.rsp_result, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        vec_t v [9];
        int   lat;
        int   acc;
        logic ok;
        logic [2:0] ef;
        v = '{
            '{3'b010, 32'h0001_FFFF, 32'h0000_0001, 32'h0002_0000, 3'b000, 3'd3},
            '{3'b110, 32'h8000_0000, 32'h0000_0001, 32'h7FFF_FFFF, 3'b011, 3'd3},
            '{3'b110, 32'h1234_5678, 32'h1234_5678, 32'h0000_0000, 3'b101, 3'd3},
            '{3'b000, 32'hF0F0_0000, 32'h0F0F_FFFF, 32'h0000_0000, 3'b100, 3'd3},
            '{3'b111, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 3'b000, 3'd4},
            '{3'b111, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 3'b100, 3'd4},
            '{3'b001, 32'h1234_0000, 32'h0000_5678, 32'h1234_5678, 3'b000, 3'd3},
            '{3'b011, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 3'b101, 3'd3},
            '{3'b111, 32'h8000_0000, 32'h0000_0001, 32'h0000_0001, 3'b000, 3'd4}
        };
        for (int i = 0; i < 9; i++) begin
            run_cmd(v[i].op, v[i].a, v[i].b, 1'b1, lat, acc, ok);
            ef = fm(v[i].fl);
            checks++;
            if (!ok) begin
                errors++;
                $display("FAIL dir%0d_timeout lat %0d", i, lat);
            end
            checks++;
            if (bus.rsp_result !== v[i].res) begin
                errors++;
                $display("FAIL dir%0d_result got %h want %h", i, bus.rsp_result, v[i].res);
            end
            checks++;
            if ({bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout} !== ef) begin
                errors++;
                $display("FAIL dir%0d_flags zoc got %b%b%b want %b", i, bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, ef);
            end
            checks++;
            if (lat != int'(v[i].lat)) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want %0d", i, lat, v[i].lat);
            end
        end
    endtask

    task automatic test_random();
        int   lat;
        int   acc;
        logic ok;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] exp;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 7));
            a = pick();
            b = ($urandom_range(0, 3) == 0) ? a : pick();
            exp = model(op, a, b);
            run_cmd(op, a, b, 1'b1, lat, acc, ok);
            checks++;
            if (!ok || lat != (op == 3'b111 ? 4 : 3)) begin
                errors++;
                $display("FAIL rnd%0d_latency op %b got %0d ok %b", i, op, lat, ok);
            end
            checks++;
            if ({bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_result} !== exp) begin
                errors++;
                $display("FAIL rnd%0d_rsp op %b a %h b %h got %b%b%b %h want %b %h", i, op, a, b,
                         bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_result, exp[34:32], exp[31:0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] ops [6];
        int   lat;
        int   acc;
        int   prev;
        logic ok;
        logic [31:0] a;
        logic [31:0] b;
        ops = '{3'b010, 3'b111, 3'b001, 3'b110, 3'b111, 3'b000};
        prev = 0;
        for (int i = 0; i < 6; i++) begin
            a = $urandom;
            b = $urandom;
            run_cmd(ops[i], a, b, 1'b1, lat, acc, ok);
            checks++;
            if (!ok || bus.rsp_result !== model(ops[i], a, b)[31:0]) begin
                errors++;
                $display("FAIL b2b%0d_result got %h want %h ok %b", i, bus.rsp_result, model(ops[i], a, b)[31:0], ok);
            end
            if (i > 0) begin
                checks++;
                if (acc - prev != (ops[i-1] == 3'b111 ? 5 : 4)) begin
                    errors++;
                    $display("FAIL b2b%0d_spacing got %0d want %0d", i, acc - prev, ops[i-1] == 3'b111 ? 5 : 4);
                end
            end
            prev = acc;
        end
    endtask

    task automatic test_backpressure();
        int   lat;
        int   acc;
        logic ok;
        logic [31:0] a;
        logic [31:0] b;
        logic [34:0] exp;
        a = $urandom;
        b = $urandom;
        exp = model(3'b110, a, b);
        run_cmd(3'b110, a, b, 1'b0, lat, acc, ok);
        checks++;
        if (!ok || {bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_result} !== exp) begin
            errors++;
            $display("FAIL bp_rsp got %h want %h ok %b", bus.rsp_result, exp[31:0], ok);
        end
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'b010;
        bus.cmd_a = ~a;
        bus.cmd_b = 32'h1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.rsp_valid !== 1'b1 || bus.cmd_ready !== 1'b0 ||
                {bus.rsp_zero, bus.rsp_ovf, bus.rsp_cout, bus.rsp_result} !== exp) begin
                errors++;
                $display("FAIL bp_hold%0d valid %b ready %b result %h want 1 0 %h", i,
                         bus.rsp_valid, bus.cmd_ready, bus.rsp_result, exp[31:0]);
            end
        end
        bus.cmd_valid = 1'b0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (bus.rsp_valid !== 1'b0 || bus.cmd_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release valid %b ready %b want 0 1", bus.rsp_valid, bus.cmd_ready);
        end
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_ignored ready %b valid %b want 1 0", bus.cmd_ready, bus.rsp_valid);
        end
    endtask

    task automatic test_reset_mid();
        int   lat;
        int   acc;
        int   seen;
        logic ok;
        run_cmd(3'b110, 32'h8000_0000, 32'h0000_0001, 1'b1, lat, acc, ok);
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op = 3'b010;
        bus.cmd_a = 32'h1111_1111;
        bus.cmd_b = 32'h2222_2222;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b0 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_busy ready %b valid %b want 0 0", bus.cmd_ready, bus.rsp_valid);
        end
        rst_n = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.cmd_ready !== 1'b1 || bus.rsp_valid !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_ctrl ready %b valid %b want 1 0", bus.cmd_ready, bus.rsp_valid);
        end
        checks++;
        if ({bus.rsp_result, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero} !== 35'b0) begin
            errors++;
            $display("FAIL rstmid_rsp got %h %b%b%b want 0", bus.rsp_result, bus.rsp_cout, bus.rsp_ovf, bus.rsp_zero);
        end
        rst_n = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid !== 1'b0) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL rstmid_no_rsp got %0d valid cycles want 0", seen);
        end
        run_cmd(3'b010, 32'h0000_FFFF, 32'h0000_0001, 1'b1, lat, acc, ok);
        checks++;
        if (!ok || bus.rsp_result !== 32'h0001_0000) begin
            errors++;
            $display("FAIL rstmid_after got %h want 00010000 ok %b", bus.rsp_result, ok);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
